// File: rtl/issue_buf.sv
// Decoded-instruction queue with in-order issue to lane 0 and, with ISSUE_DUAL_EN defined, a paired issue to lane 1.
// Latency: push at edge N, issue onto the lane registers at edge N+1 at the earliest (2 edges decoder-to-lane).
// Backpressure: in_ready drops when fewer than 2 entries are free or stop is high; stop freezes queue and lanes.
module issue_buf #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        stop,
    input  logic        in_valid0,
    input  logic        in_valid1,
    input  logic [31:0] in_pc0,
    input  logic [31:0] in_pc1,
    input  logic [31:0] in_imm0,
    input  logic [31:0] in_imm1,
    input  logic [71:0] in_dec0,
    input  logic [71:0] in_dec1,
    output logic        in_ready,
    input  logic        wb_we0,
    input  logic        wb_we1,
    input  logic [4:0]  wb_addr0,
    input  logic [4:0]  wb_addr1,
    output logic        lane0_valid,
    output logic        lane1_valid,
    output logic [31:0] lane0_pc,
    output logic [31:0] lane1_pc,
    output logic [31:0] lane0_imm,
    output logic [31:0] lane1_imm,
    output logic [71:0] lane0_dec,
    output logic [71:0] lane1_dec,
    output logic        lane0_num,
    output logic        lane1_num
);

    localparam int          AW           = $clog2(DEPTH);
    localparam logic [AW:0] ONE          = (AW+1)'(1);
    localparam logic [AW:0] PUSH_LIM     = (AW+1)'(DEPTH - 2);
    localparam logic [2:0]  NPC_PLUS4    = 3'd0;
    localparam logic [1:0]  RFW_FROM_MEM = 2'd1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [71:0] dec;
    } entry_t;

    typedef struct packed {
        logic   vld;
        entry_t ent;
    } lane_t;

    entry_t      mem_q [DEPTH];
    logic [AW:0] head, tail, count, tail_p1, push_n, issue_n;
    logic        push0, push1, issue0, issue1;
    entry_t      h0;
    lane_t       lane0_q;
    logic        lane0_we, lane1_we;
    logic [4:0]  lane0_rd, lane1_rd;

    function automatic logic src_hit(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic we, input logic [4:0] rd);
        return we && (rd != 5'd0) && ((rd == rs) || (rd == rt));
    endfunction

    // Any in-flight writer (lane registers or memory-stage wb ports) blocks a reader.
    function automatic logic hazard(input logic [4:0] rs, input logic [4:0] rt);
        return src_hit(rs, rt, lane0_we, lane0_rd) || src_hit(rs, rt, lane1_we, lane1_rd) ||
               src_hit(rs, rt, wb_we0, wb_addr0)   || src_hit(rs, rt, wb_we1, wb_addr1);
    endfunction

    function automatic logic is_mem(input logic dmwe, input logic [1:0] rfwsrc);
        return dmwe || (rfwsrc == RFW_FROM_MEM);
    endfunction

    assign count    = tail - head;
    assign tail_p1  = tail + ONE;
    assign in_ready = !stop && (count <= PUSH_LIM);
    assign push0    = in_ready && in_valid0 && !flush;
    assign push1    = push0 && in_valid1;
    assign push_n   = (AW+1)'(push0) + (AW+1)'(push1);
    assign issue_n  = (AW+1)'(issue0) + (AW+1)'(issue1);

    assign h0       = mem_q[head[AW-1:0]];
    assign issue0   = (count != '0) && !hazard(h0.dec[68:64], h0.dec[63:59]);
    assign lane0_we = lane0_q.vld && lane0_q.ent.dec[2];
    assign lane0_rd = lane0_q.ent.dec[58:54];

    always_ff @(posedge clk) begin
        if (push0) mem_q[tail[AW-1:0]]    <= '{pc: in_pc0, imm: in_imm0, dec: in_dec0};
        if (push1) mem_q[tail_p1[AW-1:0]] <= '{pc: in_pc1, imm: in_imm1, dec: in_dec1};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head    <= '0;
            tail    <= '0;
            lane0_q <= '0;
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            lane0_q <= '0;
        end else if (!stop) begin
            tail    <= tail + push_n;
            head    <= head + issue_n;
            lane0_q <= issue0 ? {1'b1, h0} : '0;
        end
    end

    assign lane0_valid = lane0_q.vld;
    assign lane0_pc    = lane0_q.ent.pc;
    assign lane0_imm   = lane0_q.ent.imm;
    assign lane0_dec   = lane0_q.ent.dec;
    assign lane0_num   = 1'b0;

`ifdef ISSUE_DUAL_EN
    logic [AW:0] head_p1;
    entry_t      h1;
    lane_t       lane1_q;
    logic        same_rd;

    assign head_p1  = head + ONE;
    assign h1       = mem_q[head_p1[AW-1:0]];
    assign same_rd  = h0.dec[2] && h1.dec[2] && (h0.dec[58:54] != 5'd0) &&
                      (h0.dec[58:54] == h1.dec[58:54]);
    // The younger slot only pairs with a non-branch, non-conflicting, single-memory-op head.
    assign issue1   = issue0 && (count != ONE) &&
                      !hazard(h1.dec[68:64], h1.dec[63:59]) &&
                      !src_hit(h1.dec[68:64], h1.dec[63:59], h0.dec[2], h0.dec[58:54]) &&
                      (h0.dec[15:13] == NPC_PLUS4) &&
                      !(is_mem(h0.dec[6], h0.dec[1:0]) && is_mem(h1.dec[6], h1.dec[1:0])) &&
                      !same_rd;
    assign lane1_we = lane1_q.vld && lane1_q.ent.dec[2];
    assign lane1_rd = lane1_q.ent.dec[58:54];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane1_q <= '0;
        end else if (flush) begin
            lane1_q <= '0;
        end else if (!stop) begin
            lane1_q <= issue1 ? {1'b1, h1} : '0;
        end
    end

    assign lane1_valid = lane1_q.vld;
    assign lane1_pc    = lane1_q.ent.pc;
    assign lane1_imm   = lane1_q.ent.imm;
    assign lane1_dec   = lane1_q.ent.dec;
    assign lane1_num   = lane1_q.vld;
`else
    assign issue1      = 1'b0;
    assign lane1_we    = 1'b0;
    assign lane1_rd    = 5'd0;
    assign lane1_valid = 1'b0;
    assign lane1_pc    = '0;
    assign lane1_imm   = '0;
    assign lane1_dec   = '0;
    assign lane1_num   = 1'b0;
`endif

endmodule
